// File: rtl/sequence_detector_param_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Imported by the top level and by the pattern comparator.
package sequence_detector_param_pkg;

    localparam logic       OVL_ON      = 1'b1;
    localparam logic       OVL_OFF     = 1'b0;
    localparam logic [7:0] DEF_PATTERN = 8'h06;
    localparam int         DEF_LEN     = 4;

    // Width needed to hold a length value in the range 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sequence_detector_param_pattern_match_cmp.sv
// Combinational compare of the newest len history bits against the programmed pattern.
// A hit also requires at least len bits received since the last restart.
module pattern_match_cmp
    import sequence_detector_param_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill,
    output logic               hit
);

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len));
        end
        hit = (((hist ^ pat) & w_mask) == '0) && (fill >= len);
    end

endmodule

// File: rtl/sequence_detector_param.sv
// Serial bit-stream detector with runtime-programmable pattern, length and overlap mode.
// Produces a registered one-cycle match pulse and a saturating match counter.
module sequence_detector_param
    import sequence_detector_param_pkg::*;
#(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 DEFAULT_LEN     = DEF_LEN,
    parameter logic               DEFAULT_OVERLAP = OVL_ON,
    parameter int                 LEN_W           = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_z;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_hit;
    logic               w_match;

    assign w_hist_next   = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_next   = (r_fill >= MAX_LEN_L) ? MAX_LEN_L : r_fill + 1'b1;
    assign w_len_clamped = (cfg_len == '0)       ? LEN_W'(1)
                         : (cfg_len > MAX_LEN_L) ? MAX_LEN_L
                         : cfg_len;

    // Compare runs on the post-shift history and fill so the pulse follows the final bit's edge.
    pattern_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist (w_hist_next),
        .pat  (r_pat),
        .len  (r_len),
        .fill (w_fill_next),
        .hit  (w_hit)
    );

    assign w_match = x_valid && !cfg_load && w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= DEFAULT_PATTERN;
            r_len  <= LEN_W'(DEFAULT_LEN);
            r_ovl  <= DEFAULT_OVERLAP;
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            r_z <= 1'b0;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_clamped;
                r_ovl  <= cfg_overlap;
                r_hist <= '0;
                r_fill <= '0;
            end else if (x_valid) begin
                r_hist <= w_hist_next;
                r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_next;
                r_z    <= w_hit;
            end
        end
    end

    // Clear takes priority over a coincident match; the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (cnt_clr) begin
            r_count <= '0;
        end else if (w_match && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign z           = r_z;
    assign match_count = r_count;

endmodule
